// File: rtl/lcd_pkg.sv
// Shared types and constants for the Spartan-3E character LCD path.
// States, default timings and the HD44780 command bytes we issue.
package lcd_pkg;

  typedef enum logic [3:0] {
    RESET,
    PWR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    CFG_HI,
    CFG_GAP,
    CFG_LO,
    CFG_WAIT,
    IDLE,
    WR_HI,
    WR_GAP,
    WR_LO,
    WR_WAIT
  } lcdState_t;

  localparam int CNT_W = 24;

  localparam int T_POWERON_DEF    = 750000;
  localparam int T_INIT_LONG_DEF  = 205000;
  localparam int T_INIT_SHORT_DEF = 5000;
  localparam int T_CMD_DEF        = 2000;
  localparam int T_CLEAR_DEF      = 82000;
  localparam int T_GAP_DEF        = 50;
  localparam int E_PULSE_DEF      = 12;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;

  // Configuration bytes in the order they are sent after init.
  function automatic logic [7:0] cfgByte(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return ENTRY;
      2'd2:    return DISP_ON;
      default: return CLEAR;
    endcase
  endfunction

  // Clear and home are the slow commands needing the long settle.
  function automatic logic isSlowCmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CLEAR || b == HOME);
  endfunction

endpackage

// File: rtl/lcd_write_scheduler_nibble_writer.sv
// Single-nibble strobe: two setup cycles, E high for E_PULSE, one hold.
// Data and RS stay on the bus until the next nibble replaces them.
module lcd_nibble_writer #(
  parameter int E_PULSE = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic [3:0] iNibble,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data
);

  localparam int CW = 8;

  logic          busy;
  logic [CW-1:0] count;

  // Count cycles from the start edge; E rises at 2, falls at E_PULSE+2.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy                <= 1'b0;
      count               <= '0;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      oDone <= 1'b0;
      if (!busy) begin
        if (iStart) begin
          busy                <= 1'b1;
          count               <= '0;
          oLCD_Data           <= iNibble;
          oLCD_RegisterSelect <= iRS;
        end
      end else begin
        count <= count + CW'(1);
        if (count == CW'(1))
          oLCD_Enabled <= 1'b1;
        if (count == CW'(E_PULSE + 1))
          oLCD_Enabled <= 1'b0;
        if (count == CW'(E_PULSE + 2)) begin
          busy  <= 1'b0;
          oDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// LCD power-on/config sequencer plus round-robin byte scheduler.
// Splits each granted byte into two nibble strobes and a settle wait.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int T_POWERON    = T_POWERON_DEF,
  parameter int T_INIT_LONG  = T_INIT_LONG_DEF,
  parameter int T_INIT_SHORT = T_INIT_SHORT_DEF,
  parameter int T_CMD        = T_CMD_DEF,
  parameter int T_CLEAR      = T_CLEAR_DEF,
  parameter int T_GAP        = T_GAP_DEF,
  parameter int E_PULSE      = E_PULSE_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] iReq,
  input  logic [1:0] iRS,
  input  logic [7:0] iData0,
  input  logic [7:0] iData1,
  output logic [1:0] oGrant,
  output logic [1:0] oDone,
  output logic       oReady,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  lcdState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] waitLim;
  logic             waitEnd;
  logic [1:0]       step;
  logic [7:0]       byteReg;
  logic             rsReg;
  logic             lastGrant;
  logic             nibStart;
  logic [3:0]       nibble;
  logic             nibDone;
  logic [7:0]       cfgNext;
  logic             pick;
  logic [7:0]       pickData;

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // Length of the wait the current state is timing (minus one).
  always_comb begin
    waitLim = CNT_W'(T_CMD - 1);
    unique case (1'b1)
      state == PWR_WAIT:
        waitLim = CNT_W'(T_POWERON - 1);
      state == INIT_WAIT && step == 2'd0:
        waitLim = CNT_W'(T_INIT_LONG - 1);
      state == INIT_WAIT && step == 2'd1:
        waitLim = CNT_W'(T_INIT_SHORT - 1);
      state == CFG_GAP || state == WR_GAP:
        waitLim = CNT_W'(T_GAP - 1);
      state == CFG_WAIT && step == 2'd3:
        waitLim = CNT_W'(T_CLEAR - 1);
      state == WR_WAIT && isSlowCmd(rsReg, byteReg):
        waitLim = CNT_W'(T_CLEAR - 1);
      default: ;
    endcase
  end

  assign waitEnd  = (cnt == waitLim);
  assign cfgNext  = cfgByte(step + 2'd1);
  assign pick     = (iReq == 2'b11) ? ~lastGrant : iReq[1];
  assign pickData = pick ? iData1 : iData0;

  // Sequencer: init nibbles, config bytes, then arbitrated writes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= RESET;
      cnt       <= '0;
      step      <= 2'd0;
      byteReg   <= 8'h00;
      rsReg     <= 1'b0;
      lastGrant <= 1'b1;
      nibStart  <= 1'b0;
      nibble    <= 4'h0;
      oGrant    <= 2'b00;
      oDone     <= 2'b00;
      oReady    <= 1'b0;
    end else begin
      nibStart <= 1'b0;
      oGrant   <= 2'b00;
      oDone    <= 2'b00;
      cnt      <= cnt + CNT_W'(1);
      unique case (state)
        RESET: begin
          state <= PWR_WAIT;
          cnt   <= '0;
        end
        PWR_WAIT: if (waitEnd) begin
          state    <= INIT_NIB;
          step     <= 2'd0;
          rsReg    <= 1'b0;
          nibble   <= 4'h3;
          nibStart <= 1'b1;
        end
        INIT_NIB: if (nibDone) begin
          state <= INIT_WAIT;
          cnt   <= '0;
        end
        INIT_WAIT: if (waitEnd) begin
          nibStart <= 1'b1;
          if (step == 2'd3) begin
            state   <= CFG_HI;
            step    <= 2'd0;
            byteReg <= FUNC_SET;
            nibble  <= FUNC_SET[7:4];
          end else begin
            state  <= INIT_NIB;
            step   <= step + 2'd1;
            nibble <= (step == 2'd2) ? 4'h2 : 4'h3;
          end
        end
        CFG_HI: if (nibDone) begin
          state <= CFG_GAP;
          cnt   <= '0;
        end
        CFG_GAP: if (waitEnd) begin
          state    <= CFG_LO;
          nibble   <= byteReg[3:0];
          nibStart <= 1'b1;
        end
        CFG_LO: if (nibDone) begin
          state <= CFG_WAIT;
          cnt   <= '0;
        end
        CFG_WAIT: if (waitEnd) begin
          if (step == 2'd3) begin
            state  <= IDLE;
            oReady <= 1'b1;
          end else begin
            state    <= CFG_HI;
            step     <= step + 2'd1;
            byteReg  <= cfgNext;
            nibble   <= cfgNext[7:4];
            nibStart <= 1'b1;
          end
        end
        IDLE: if (|iReq) begin
          state     <= WR_HI;
          lastGrant <= pick;
          oGrant    <= pick ? 2'b10 : 2'b01;
          oReady    <= 1'b0;
          byteReg   <= pickData;
          rsReg     <= iRS[pick];
          nibble    <= pickData[7:4];
          nibStart  <= 1'b1;
        end
        WR_HI: if (nibDone) begin
          state <= WR_GAP;
          cnt   <= '0;
        end
        WR_GAP: if (waitEnd) begin
          state    <= WR_LO;
          nibble   <= byteReg[3:0];
          nibStart <= 1'b1;
        end
        WR_LO: if (nibDone) begin
          state <= WR_WAIT;
          cnt   <= '0;
        end
        WR_WAIT: if (waitEnd) begin
          state  <= IDLE;
          oReady <= 1'b1;
          oDone  <= lastGrant ? 2'b10 : 2'b01;
        end
        default: state <= RESET;
      endcase
    end
  end

  lcd_nibble_writer #(
    .E_PULSE(E_PULSE)
  ) uWriter (
    .Clock              (Clock),
    .Reset              (Reset),
    .iStart             (nibStart),
    .iRS                (rsReg),
    .iNibble            (nibble),
    .oDone              (nibDone),
    .oLCD_Enabled       (oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_Data          (oLCD_Data)
  );

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler with shortened timings.
// Pin-level pulse monitor checked against a phase-level timing model.
module tb_lcd_write_scheduler;

  localparam int TP  = 20;
  localparam int TL  = 10;
  localparam int TS  = 7;
  localparam int TC  = 5;
  localparam int TCL = 9;
  localparam int TG  = 3;
  localparam int EP  = 4;
  localparam int NIB = EP + 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] iReq;
  logic [1:0] iRS;
  logic [7:0] iData0;
  logic [7:0] iData1;
  logic [1:0] oGrant;
  logic [1:0] oDone;
  logic       oReady;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_write_scheduler #(
    .T_POWERON   (TP),
    .T_INIT_LONG (TL),
    .T_INIT_SHORT(TS),
    .T_CMD       (TC),
    .T_CLEAR     (TCL),
    .T_GAP       (TG),
    .E_PULSE     (EP)
  ) dut (
    .Clock                  (Clock),
    .Reset                  (Reset),
    .iReq                   (iReq),
    .iRS                    (iRS),
    .iData0                 (iData0),
    .iData1                 (iData1),
    .oGrant                 (oGrant),
    .oDone                  (oDone),
    .oReady                 (oReady),
    .oLCD_Enabled           (oLCD_Enabled),
    .oLCD_RegisterSelect    (oLCD_RegisterSelect),
    .oLCD_ReadWrite         (oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data              (oLCD_Data)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         riseT;
    int         fallT;
    logic [3:0] data;
    logic       rs;
    logic       ok;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  int     cyc = 0;
  int     errs = 0;
  int     checks = 0;
  int     grantsSeen = 0;
  int     donesSeen = 0;
  logic       prevE = 1'b0;
  logic [3:0] d1 = 4'h0, d2 = 4'h0;
  logic       r1 = 1'b0, r2 = 1'b0;

  // model state
  logic       pend[2];
  logic [7:0] bData[2];
  logic       bRs[2];
  int         reqCyc[2];
  int         last;
  int         lastDone;

  always @(posedge Clock) cyc <= cyc + 1;

  // Capture every E pulse: timing, value, setup/stable/hold integrity.
  always @(negedge Clock) begin
    if (oLCD_Enabled && !prevE) begin
      cur.riseT = cyc;
      cur.data  = oLCD_Data;
      cur.rs    = oLCD_RegisterSelect;
      cur.ok    = (d1 == oLCD_Data) && (d2 == oLCD_Data) &&
                  (r1 == oLCD_RegisterSelect) && (r2 == oLCD_RegisterSelect);
    end else if (oLCD_Enabled && prevE) begin
      cur.ok = cur.ok && (oLCD_Data == cur.data) &&
               (oLCD_RegisterSelect == cur.rs);
    end else if (!oLCD_Enabled && prevE) begin
      cur.fallT = cyc;
      cur.ok = cur.ok && (oLCD_Data == cur.data) &&
               (oLCD_RegisterSelect == cur.rs);
      pulses.push_back(cur);
    end
    if (oGrant != 2'b00) grantsSeen++;
    if (oDone != 2'b00) donesSeen++;
    d2 = d1; d1 = oLCD_Data;
    r2 = r1; r1 = oLCD_RegisterSelect;
    prevE = oLCD_Enabled;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [13:0] pk(input pulse_t p);
    return {p.ok, p.rs, 8'(p.fallT - p.riseT), p.data};
  endfunction

  function automatic int settle(input logic rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02)) ? TCL : TC;
  endfunction

  // Run the power-on sequence from a just-released reset and verify it.
  task automatic initCheck();
    logic [3:0] expNib[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                               4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    int gapAfter[12] = '{TL, TS, TC, TC, TG, TC, TG, TC, TG, TC, TG, TCL};
    int g0, readyT, n;
    g0 = grantsSeen;
    readyT = -1;
    for (int i = 0; i < 3000 && readyT < 0; i++) begin
      @(negedge Clock);
      if (i == 6) iReq[0] = 1'b1;
      if (i == 7) iReq[0] = 1'b0;
      if (oReady) readyT = cyc;
    end
    check("initReady", readyT >= 0, 1);
    check("initNoGrant", grantsSeen, g0);
    n = pulses.size();
    check("initPulses", n, 12);
    if (n == 12 && readyT >= 0) begin
      for (int i = 0; i < 12; i++) begin
        check($sformatf("initNib%0d", i), pk(pulses[i]),
              {1'b1, 1'b0, 8'(EP), expNib[i]});
        if (i > 0)
          check($sformatf("initGap%0d", i),
                pulses[i].riseT - pulses[i-1].fallT, gapAfter[i-1] + 5);
      end
      check("readyTime", readyT - pulses[11].fallT, TCL + 2);
    end
    pulses.delete();
    lastDone = readyT;
  endtask

  task automatic request(input int i, input logic rs, input logic [7:0] d);
    bData[i] = d;
    bRs[i] = rs;
    iRS[i] = rs;
    if (i == 0) iData0 = d;
    else iData1 = d;
    iReq[i] = 1'b1;
    pend[i] = 1'b1;
    reqCyc[i] = cyc;
  endtask

  // Wait for one grant, then check the whole byte transaction.
  task automatic serveOne();
    int w, g, doneT, expG, wt;
    logic [1:0] gnt, dn;
    w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
    gnt = 2'b00;
    for (int i = 0; i < 100 && gnt == 2'b00; i++) begin
      @(negedge Clock);
      gnt = oGrant;
    end
    check("grant", gnt, 2'b01 << w);
    if (gnt == 2'b00) begin
      iReq = 2'b00; pend[0] = 1'b0; pend[1] = 1'b0;
      return;
    end
    g = cyc;
    expG = (lastDone + 1 > reqCyc[w] + 1) ? lastDone + 1 : reqCyc[w] + 1;
    check("grantTime", g, expG);
    check("readyDrop", oReady, 0);
    iReq[w] = 1'b0;
    pend[w] = 1'b0;
    last = w;
    pulses.delete();
    wt = settle(bRs[w], bData[w]);
    dn = 2'b00;
    for (int i = 0; i < 300 && dn == 2'b00; i++) begin
      @(negedge Clock);
      dn = oDone;
    end
    doneT = cyc;
    check("done", dn, 2'b01 << w);
    check("doneTime", doneT - g, 2 * NIB + TG + wt + 4);
    check("readyBack", oReady, 1);
    check("pulseCnt", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("hiNib", pk(pulses[0]), {1'b1, bRs[w], 8'(EP), bData[w][7:4]});
      check("loNib", pk(pulses[1]), {1'b1, bRs[w], 8'(EP), bData[w][3:0]});
      check("hiRise", pulses[0].riseT - g, 3);
      check("loGap", pulses[1].riseT - pulses[0].fallT, TG + 5);
    end
    pulses.delete();
    lastDone = doneT;
  endtask

  task automatic serveAll();
    while (pend[0] || pend[1]) serveOne();
  endtask

  task automatic applyReset(input int n);
    Reset = 1'b1;
    iReq = 2'b00;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1;
    repeat (n) @(negedge Clock);
    Reset = 1'b0;
    pulses.delete();
  endtask

  initial begin
    int g, dn0, gr0, r, m;
    logic [7:0] b;
    logic rs;
    Reset = 1'b1;
    iReq = 2'b00;
    iRS = 2'b00;
    iData0 = 8'h00;
    iData1 = 8'h00;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1;
    lastDone = 0;
    repeat (3) @(negedge Clock);
    check("rstVals", {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data,
                      oGrant, oDone, oReady}, 0);
    check("rwSf", {oLCD_ReadWrite, oLCD_StrataFlashControl}, 2'b01);
    applyReset(0);
    initCheck();

    // both requesters together, twice
    for (int k = 0; k < 2; k++) begin
      request(0, 1'b1, 8'h30 + 8'(k));
      request(1, 1'b1, 8'h50 + 8'(k));
      serveAll();
    end

    request(0, 1'b1, 8'h41);
    serveAll();
    request(1, 1'b0, 8'h01);
    serveAll();
    request(1, 1'b0, 8'h80);
    serveAll();

    for (int t = 0; t < 16; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge Clock);
      m = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (m[i]) begin
          r = $urandom_range(0, 9);
          b = (r < 2) ? 8'h01 : (r == 2) ? 8'h02 : 8'($urandom);
          rs = (r < 3) ? 1'b0 : 1'($urandom_range(0, 1));
          request(i, rs, b);
        end
      end
      serveAll();
    end

    // reset while the low nibble strobe is high
    @(negedge Clock);
    request(0, 1'b1, 8'h5A);
    for (int i = 0; i < 100 && oGrant == 2'b00; i++) @(negedge Clock);
    check("midGrant", oGrant, 2'b01);
    g = cyc;
    iReq[0] = 1'b0;
    pend[0] = 1'b0;
    while (cyc < g + 3 + EP + TG + 5 + 1) @(negedge Clock);
    check("midLoHigh", {oLCD_Enabled, oLCD_Data}, {1'b1, 4'hA});
    dn0 = donesSeen;
    gr0 = grantsSeen;
    Reset = 1'b1;
    @(negedge Clock);
    check("midRstVals", {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data,
                         oGrant, oDone, oReady}, 0);
    applyReset(2);
    initCheck();
    check("midNoDone", donesSeen, dn0);
    check("midNoGrant", grantsSeen, gr0);

    request(1, 1'b1, 8'hC3);
    request(0, 1'b0, 8'h02);
    serveAll();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
